mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-port (fetch / data) round-robin arbiter for a single memory bus.
//   Sequence per transaction: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//   All outputs are registered.
//
//   Optional feature macro: MEM_BUS_ARBITER_TIMEOUT_EN
//     When defined, an ACCESS that sees no M_MOC for TIMEOUT_CYCLES cycles
//     is aborted: DONE pulses together with ERR and the read register is
//     loaded with 0. When undefined, ACCESS waits for M_MOC indefinitely
//     and ERR is tied low.
//
// Ports
//   CLK, CLR                  clock, async active-high reset
//   F_REQ, F_ADDR             fetch request (held until F_DONE) and address
//   F_DONE, F_DATA            fetch complete pulse, fetch read data
//   D_REQ, D_RW, D_ADDR,      data request (held until D_DONE), 1 = read,
//   D_WDATA, D_SIZE, D_SIGN   address, write data, size, sign-extend flag
//   D_DONE, D_RDATA           data complete pulse, data read result
//   M_MOV, M_RW, M_ADDR,      memory operation valid, 1 = read, address,
//   M_WDATA, M_SIZE, M_SIGN   write data, size, sign
//   M_MOC, M_RDATA            memory operation complete, memory read data
//   BUSY                      high in every state except IDLE
//   ERR                       pulse with DONE when the access was aborted
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        F_REQ,
   input  logic [31:0] F_ADDR,
   output logic        F_DONE,
   output logic [31:0] F_DATA,
   input  logic        D_REQ,
   input  logic        D_RW,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   input  logic [1:0]  D_SIZE,
   input  logic        D_SIGN,
   output logic        D_DONE,
   output logic [31:0] D_RDATA,
   output logic        M_MOV,
   output logic        M_RW,
   output logic [31:0] M_ADDR,
   output logic [31:0] M_WDATA,
   output logic [1:0]  M_SIZE,
   output logic        M_SIGN,
   input  logic        M_MOC,
   input  logic [31:0] M_RDATA,
   output logic        BUSY,
   output logic        ERR
);

   // The ACCESS counter is 4 bits wide, so the limit must fit in 1..15.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_timeout_range
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state;
   logic   last_d;   // 1: data port was served last
   logic   win_d;    // 1: current transaction belongs to the data port
   logic   grant_d;

   // Data wins when alone, or on contention when fetch was served last.
   // Reset clears last_d, so data wins the first contention.
   assign grant_d = D_REQ & (~F_REQ | ~last_d);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);
   logic [3:0] cnt;
`else
   assign ERR = 1'b0;
`endif

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state   <= IDLE;
         last_d  <= 1'b0;
         win_d   <= 1'b0;
         F_DONE  <= 1'b0;
         F_DATA  <= '0;
         D_DONE  <= 1'b0;
         D_RDATA <= '0;
         M_MOV   <= 1'b0;
         M_RW    <= 1'b0;
         M_ADDR  <= '0;
         M_WDATA <= '0;
         M_SIZE  <= '0;
         M_SIGN  <= 1'b0;
         BUSY    <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
         cnt     <= '0;
         ERR     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (F_REQ || D_REQ) begin
                  state <= SETUP;
                  BUSY  <= 1'b1;
                  win_d <= grant_d;
                  if (grant_d) begin
                     M_RW    <= D_RW;
                     M_ADDR  <= D_ADDR;
                     M_WDATA <= D_WDATA;
                     M_SIZE  <= D_SIZE;
                     M_SIGN  <= D_SIGN;
                  end else begin
                     // Fetch is always a full-word unsigned read.
                     M_RW    <= 1'b1;
                     M_ADDR  <= F_ADDR;
                     M_WDATA <= '0;
                     M_SIZE  <= 2'b10;
                     M_SIGN  <= 1'b0;
                  end
               end
            end
            SETUP: begin
               state <= ACCESS;
               M_MOV <= 1'b1;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            ACCESS: begin
               if (M_MOC) begin
                  state <= DONE;
                  M_MOV <= 1'b0;
                  if (win_d) begin
                     D_DONE <= 1'b1;
                     if (M_RW) D_RDATA <= M_RDATA;
                  end else begin
                     F_DONE <= 1'b1;
                     F_DATA <= M_RDATA;
                  end
               end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
               else if (cnt == TO_LAST) begin
                  state <= DONE;
                  M_MOV <= 1'b0;
                  ERR   <= 1'b1;
                  if (win_d) begin
                     D_DONE  <= 1'b1;
                     D_RDATA <= '0;
                  end else begin
                     F_DONE <= 1'b1;
                     F_DATA <= '0;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
`endif
            end
            DONE: begin
               state  <= IDLE;
               BUSY   <= 1'b0;
               F_DONE <= 1'b0;
               D_DONE <= 1'b0;
               last_d <= win_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
               ERR    <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed, table-driven bench for mem_bus_arbiter. Cycle n is the
//   interval after rising edge n; requests are driven in cycle 0 and
//   outputs are sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        F_REQ;
   logic [31:0] F_ADDR;
   logic        F_DONE;
   logic [31:0] F_DATA;
   logic        D_REQ;
   logic        D_RW;
   logic [31:0] D_ADDR;
   logic [31:0] D_WDATA;
   logic [1:0]  D_SIZE;
   logic        D_SIGN;
   logic        D_DONE;
   logic [31:0] D_RDATA;
   logic        M_MOV;
   logic        M_RW;
   logic [31:0] M_ADDR;
   logic [31:0] M_WDATA;
   logic [1:0]  M_SIZE;
   logic        M_SIGN;
   logic        M_MOC;
   logic [31:0] M_RDATA;
   logic        BUSY;
   logic        ERR;

   int unsigned errors = 0;
   int unsigned checks = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(15)) dut (
      .CLK(CLK), .CLR(CLR),
      .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_DONE(F_DONE), .F_DATA(F_DATA),
      .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_SIZE(D_SIZE), .D_SIGN(D_SIGN), .D_DONE(D_DONE), .D_RDATA(D_RDATA),
      .M_MOV(M_MOV), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
      .M_SIZE(M_SIZE), .M_SIGN(M_SIGN), .M_MOC(M_MOC), .M_RDATA(M_RDATA),
      .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        is_data;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] rdata;
      int unsigned waits;     // ACCESS cycles with M_MOC low before completion
      logic        spur;      // pulse M_MOC in IDLE/SETUP, must be ignored
      logic        exp_rw;
      logic [1:0]  exp_size;
      logic        exp_sign;
      logic [31:0] exp_rd;    // winner's read register after DONE
      int unsigned lat;       // cycle in which DONE is expected
   } vec_t;

   function automatic vec_t mk(input logic is_data, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic sign,
                               input logic [31:0] rdata, input int unsigned waits,
                               input logic spur, input logic exp_rw,
                               input logic [1:0] exp_size, input logic exp_sign,
                               input logic [31:0] exp_rd, input int unsigned lat);
      vec_t v;
      v.is_data = is_data; v.rw = rw; v.addr = addr; v.wdata = wdata;
      v.size = size; v.sign = sign; v.rdata = rdata; v.waits = waits;
      v.spur = spur; v.exp_rw = exp_rw; v.exp_size = exp_size;
      v.exp_sign = exp_sign; v.exp_rd = exp_rd; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      F_REQ = 1'b0; F_ADDR = '0;
      D_REQ = 1'b0; D_RW = 1'b0; D_ADDR = '0; D_WDATA = '0;
      D_SIZE = '0; D_SIGN = 1'b0;
      M_MOC = 1'b0; M_RDATA = '0;
   endtask

   // One lone-requester transaction, checked every cycle.
   task automatic apply_vec(input vec_t v, input string tag);
      if (v.is_data) begin
         D_REQ = 1'b1; D_RW = v.rw; D_ADDR = v.addr; D_WDATA = v.wdata;
         D_SIZE = v.size; D_SIGN = v.sign;
         F_REQ = 1'b0; F_ADDR = 32'hFFFF_FFF0;
      end else begin
         F_REQ = 1'b1; F_ADDR = v.addr;
         // Idle data-port fields must not leak into the fetch latches.
         D_REQ = 1'b0; D_RW = 1'b0; D_ADDR = 32'hBAD0_BAD0;
         D_WDATA = 32'h0BAD_F00D; D_SIZE = 2'b01; D_SIGN = 1'b1;
      end
      for (int unsigned c = 0; c < v.lat; c++) begin
         M_MOC   = (c == 2 + v.waits) || (v.spur && c < 2);
         M_RDATA = (c == 2 + v.waits) ? v.rdata : 32'h9999_9999;
         step();
         chk($sformatf("%s c%0d busy", tag, c + 1), BUSY, 1'b1);
         chk($sformatf("%s c%0d mov", tag, c + 1), M_MOV,
             (c + 1 >= 2 && c + 1 <= 2 + v.waits));
         chk($sformatf("%s c%0d addr", tag, c + 1), M_ADDR, v.addr);
         chk($sformatf("%s c%0d rw", tag, c + 1), M_RW, v.exp_rw);
         chk($sformatf("%s c%0d size", tag, c + 1), M_SIZE, v.exp_size);
         chk($sformatf("%s c%0d sign", tag, c + 1), M_SIGN, v.exp_sign);
         if (v.is_data && !v.rw)
            chk($sformatf("%s c%0d wdata", tag, c + 1), M_WDATA, v.wdata);
         chk($sformatf("%s c%0d f_done", tag, c + 1), F_DONE, (!v.is_data && c + 1 == v.lat));
         chk($sformatf("%s c%0d d_done", tag, c + 1), D_DONE, (v.is_data && c + 1 == v.lat));
         chk($sformatf("%s c%0d err", tag, c + 1), ERR, 1'b0);
      end
      if (v.is_data) chk({tag, " d_rdata"}, D_RDATA, v.exp_rd);
      else           chk({tag, " f_data"}, F_DATA, v.exp_rd);
      F_REQ = 1'b0; D_REQ = 1'b0; M_MOC = 1'b0;
      step();
      chk({tag, " idle busy"}, BUSY, 1'b0);
      chk({tag, " idle f_done"}, F_DONE, 1'b0);
      chk({tag, " idle d_done"}, D_DONE, 1'b0);
      chk({tag, " idle mov"}, M_MOV, 1'b0);
   endtask

   // Both ports request together; M_MOC held high so each ACCESS is one cycle.
   task automatic contend(input logic data_first, input logic [31:0] exp_drd, input string tag);
      int d_cyc = -1;
      int f_cyc = -1;
      F_REQ = 1'b1; F_ADDR = 32'h0000_0010;
      D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 32'h0000_0020; D_WDATA = 32'hDEAD_BEEF;
      D_SIZE = 2'b10; D_SIGN = 1'b0;
      M_MOC = 1'b1; M_RDATA = 32'hCAFE_F00D;
      for (int c = 1; c <= 10; c++) begin
         step();
         if ((c == 2 && data_first) || (c == 6 && !data_first)) begin
            chk($sformatf("%s c%0d data rw", tag, c), M_RW, 1'b0);
            chk($sformatf("%s c%0d data addr", tag, c), M_ADDR, 32'h0000_0020);
            chk($sformatf("%s c%0d data wdata", tag, c), M_WDATA, 32'hDEAD_BEEF);
         end
         if ((c == 2 && !data_first) || (c == 6 && data_first)) begin
            chk($sformatf("%s c%0d fetch rw", tag, c), M_RW, 1'b1);
            chk($sformatf("%s c%0d fetch addr", tag, c), M_ADDR, 32'h0000_0010);
            chk($sformatf("%s c%0d fetch size", tag, c), M_SIZE, 2'b10);
         end
         if (D_DONE && F_DONE) chk($sformatf("%s c%0d both done", tag, c), 1'b1, 1'b0);
         if (D_DONE && d_cyc < 0) begin d_cyc = c; D_REQ = 1'b0; end
         if (F_DONE && f_cyc < 0) begin f_cyc = c; F_REQ = 1'b0; end
      end
      chk({tag, " d_done cycle"}, d_cyc, data_first ? 3 : 7);
      chk({tag, " f_done cycle"}, f_cyc, data_first ? 7 : 3);
      chk({tag, " f_data"}, F_DATA, 32'hCAFE_F00D);
      chk({tag, " d_rdata kept on write"}, D_RDATA, exp_drd);
      idle_inputs();
      step();
      chk({tag, " end busy"}, BUSY, 1'b0);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = mk(1'b0, 1'b1, 32'h0000_0010, 32'h0, 2'b00, 1'b0, 32'hE3A0_1005, 0, 1'b0,
                   1'b1, 2'b10, 1'b0, 32'hE3A0_1005, 3);
      vecs[1] = mk(1'b1, 1'b1, 32'h0000_0100, 32'h0, 2'b00, 1'b1, 32'hFFFF_FF80, 0, 1'b0,
                   1'b1, 2'b00, 1'b1, 32'hFFFF_FF80, 3);
      vecs[2] = mk(1'b1, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h5555_5555, 1, 1'b0,
                   1'b0, 2'b10, 1'b0, 32'hFFFF_FF80, 4);
      vecs[3] = mk(1'b0, 1'b1, 32'h0000_0014, 32'h0, 2'b00, 1'b0, 32'hE59F_0004, 2, 1'b1,
                   1'b1, 2'b10, 1'b0, 32'hE59F_0004, 5);
      vecs[4] = mk(1'b1, 1'b1, 32'h0000_0044, 32'h0, 2'b01, 1'b0, 32'h1234_ABCD, 5, 1'b0,
                   1'b1, 2'b01, 1'b0, 32'h1234_ABCD, 8);

      // Reset state
      idle_inputs();
      CLR = 1'b1;
      step();
      step();
      chk("rst busy", BUSY, 1'b0);
      chk("rst mov", M_MOV, 1'b0);
      chk("rst f_done", F_DONE, 1'b0);
      chk("rst d_done", D_DONE, 1'b0);
      chk("rst err", ERR, 1'b0);
      chk("rst f_data", F_DATA, 32'h0);
      chk("rst d_rdata", D_RDATA, 32'h0);
      chk("rst m_addr", M_ADDR, 32'h0);
      chk("rst m_wdata", M_WDATA, 32'h0);
      CLR = 1'b0;
      step();

      // Lone requesters; the last one is a data access.
      for (int i = 0; i < 5; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

      // Data served last, so fetch wins this contention.
      contend(1'b0, 32'h1234_ABCD, "rr_fetch");

      // Reset in the middle of ACCESS
      D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 32'h0000_0080; D_SIZE = 2'b10;
      step();
      step();
      chk("mid mov before reset", M_MOV, 1'b1);
      #2;
      CLR = 1'b1;
      #1;
      chk("mid mov async", M_MOV, 1'b0);
      chk("mid busy async", BUSY, 1'b0);
      chk("mid d_rdata async", D_RDATA, 32'h0);
      chk("mid m_addr async", M_ADDR, 32'h0);
      D_REQ = 1'b0;
      M_MOC = 1'b1; M_RDATA = 32'h7777_7777;
      step();
      CLR = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("mid c%0d no d_done", c), D_DONE, 1'b0);
         chk($sformatf("mid c%0d busy", c), BUSY, 1'b0);
      end
      M_MOC = 1'b0;
      apply_vec(mk(1'b1, 1'b1, 32'h0000_0080, 32'h0, 2'b10, 1'b0, 32'h600D_CAFE, 0, 1'b0,
                   1'b1, 2'b10, 1'b0, 32'h600D_CAFE, 3), "post_rst");

      // M_MOC never arrives
      D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 32'h0000_0090; D_SIZE = 2'b10;
      M_MOC = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      begin
         int to_cyc = -1;
         for (int c = 1; c <= 25; c++) begin
            step();
            if (D_DONE && to_cyc < 0) begin
               to_cyc = c;
               chk("to err", ERR, 1'b1);
               chk("to d_rdata", D_RDATA, 32'h0);
               chk("to mov", M_MOV, 1'b0);
               D_REQ = 1'b0;
            end else if (ERR) begin
               chk($sformatf("to c%0d stray err", c), ERR, 1'b0);
            end
         end
         chk("to done cycle", to_cyc, 17);
         chk("to end busy", BUSY, 1'b0);
      end
`else
      for (int c = 1; c <= 40; c++) begin
         step();
         if (D_DONE) chk($sformatf("hang c%0d d_done", c), D_DONE, 1'b0);
      end
      chk("hang busy", BUSY, 1'b1);
      chk("hang mov", M_MOV, 1'b1);
      chk("hang err", ERR, 1'b0);
`endif
      idle_inputs();
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      step();

      // After reset the data port wins the first contention.
      contend(1'b1, 32'h0, "rst_data");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
